// File: rtl/wb_regbank_gen.sv
// Wishbone register bank with NREGS word registers. Each register is either
// internal storage or an external register reached through a request/ack handshake.
module wb_regbank_gen #(
  parameter int unsigned      NREGS    = 4,
  parameter int unsigned      ADDR_W   = 2,
  parameter int unsigned      DW       = 32,
  parameter logic [NREGS-1:0] EXT_MASK = NREGS'(4'b1100),
  parameter logic [DW-1:0]    RST_VAL  = '0,
  parameter int unsigned      TIMEOUT  = 8
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [ADDR_W-1:0]   wb_adr_i,
  input  logic [DW/8-1:0]     wb_sel_i,
  input  logic [DW-1:0]       wb_dat_i,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic                wb_stall_o,
  output logic                wb_rty_o,
  output logic [DW-1:0]       wb_dat_o,
  output logic [NREGS*DW-1:0] reg_o,
  output logic [NREGS-1:0]    reg_wr_o,
  output logic [DW-1:0]       ext_dat_o,
  output logic [NREGS-1:0]    ext_wr_o,
  output logic [NREGS-1:0]    ext_rd_o,
  input  logic [NREGS*DW-1:0] ext_dat_i,
  input  logic [NREGS-1:0]    ext_wack_i,
  input  logic [NREGS-1:0]    ext_rack_i
);

  localparam int unsigned SW    = DW / 8;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [DW-1:0]     regs [NREGS];
  logic [ADDR_W-1:0] cur_idx;
  logic              cur_we;
  logic [CNT_W-1:0]  cnt;

  logic              req_c;
  logic              in_range_c;
  logic              is_ext_c;
  logic [DW-1:0]     rd_val_c;
  logic              ext_ack_c;
  logic [DW-1:0]     ext_rdat_c;

  assign wb_rty_o = 1'b0;

  // Decode of the incoming address and of the external register being waited on
  always_comb begin
    req_c      = wb_cyc_i & wb_stb_i;
    in_range_c = ({1'b0, wb_adr_i} < (ADDR_W + 1)'(NREGS));
    is_ext_c   = 1'b0;
    rd_val_c   = '0;
    ext_ack_c  = 1'b0;
    ext_rdat_c = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (wb_adr_i == ADDR_W'(i)) begin
        is_ext_c = EXT_MASK[i];
        rd_val_c = regs[i];
      end
      if (cur_idx == ADDR_W'(i)) begin
        ext_ack_c  = cur_we ? ext_wack_i[i] : ext_rack_i[i];
        ext_rdat_c = ext_dat_i[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      cur_idx    <= '0;
      cur_we     <= 1'b0;
      cnt        <= '0;
      wb_ack_o   <= 1'b0;
      wb_err_o   <= 1'b0;
      wb_stall_o <= 1'b0;
      wb_dat_o   <= '0;
      reg_wr_o   <= '0;
      ext_dat_o  <= '0;
      ext_wr_o   <= '0;
      ext_rd_o   <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= RST_VAL;
    end else begin
      // Response and request strobes are single-cycle pulses
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      reg_wr_o <= '0;
      ext_wr_o <= '0;
      ext_rd_o <= '0;
      case (state)
        IDLE: begin
          if (req_c) begin
            cur_idx    <= wb_adr_i;
            cur_we     <= wb_we_i;
            wb_stall_o <= 1'b1;
            if (!in_range_c) begin
              state    <= RESP;
              wb_err_o <= 1'b1;
              if (!wb_we_i) wb_dat_o <= '0;
            end else if (is_ext_c) begin
              state     <= WAIT;
              cnt       <= '0;
              ext_dat_o <= wb_dat_i;
              for (int i = 0; i < NREGS; i++) begin
                if (wb_adr_i == ADDR_W'(i)) begin
                  ext_wr_o[i] <= wb_we_i;
                  ext_rd_o[i] <= ~wb_we_i;
                end
              end
            end else begin
              state    <= RESP;
              wb_ack_o <= 1'b1;
              if (wb_we_i) begin
                for (int i = 0; i < NREGS; i++) begin
                  if (wb_adr_i == ADDR_W'(i) && !EXT_MASK[i]) begin
                    reg_wr_o[i] <= 1'b1;
                    for (int k = 0; k < SW; k++)
                      if (wb_sel_i[k]) regs[i][8*k +: 8] <= wb_dat_i[8*k +: 8];
                  end
                end
              end else begin
                wb_dat_o <= rd_val_c;
              end
            end
          end
        end
        WAIT: begin
          // Master abort beats a simultaneous ack; ack beats a simultaneous timeout
          if (!wb_cyc_i) begin
            state      <= IDLE;
            wb_stall_o <= 1'b0;
          end else if (ext_ack_c) begin
            state    <= RESP;
            wb_ack_o <= 1'b1;
            if (!cur_we) wb_dat_o <= ext_rdat_c;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state    <= RESP;
            wb_err_o <= 1'b1;
            if (!cur_we) wb_dat_o <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          state      <= IDLE;
          wb_stall_o <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          wb_stall_o <= 1'b0;
        end
      endcase
    end
  end

  // External slices of reg_o read as zero
  for (genvar g = 0; g < NREGS; g++) begin : g_reg_o
    assign reg_o[g*DW +: DW] = EXT_MASK[g] ? '0 : regs[g];
  end

endmodule

// File: tb/tb_wb_regbank_gen.sv
// Bench for wb_regbank_gen: directed vector table, randomized transactions against
// an abstract model, and hand sequences for master abort and mid-transaction reset.
module tb_wb_regbank_gen;

  localparam int       TO  = 8;
  localparam logic [3:0] EXT = 4'b1100;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cyc, stb, we;
  logic [1:0]   adr;
  logic [3:0]   sel;
  logic [31:0]  dat;
  logic         ack, err, stall, rty;
  logic [31:0]  dat_o;
  logic [127:0] reg_o;
  logic [3:0]   reg_wr;
  logic [31:0]  ext_dat_o;
  logic [3:0]   ext_wr, ext_rd;
  logic [127:0] ext_dat_i;
  logic [3:0]   ext_wack, ext_rack;

  always #5 clk = ~clk;

  wb_regbank_gen #(
    .NREGS(4), .ADDR_W(2), .DW(32), .EXT_MASK(4'b1100), .RST_VAL(32'h0), .TIMEOUT(8)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
    .wb_sel_i(sel), .wb_dat_i(dat),
    .wb_ack_o(ack), .wb_err_o(err), .wb_stall_o(stall), .wb_rty_o(rty),
    .wb_dat_o(dat_o), .reg_o(reg_o), .reg_wr_o(reg_wr),
    .ext_dat_o(ext_dat_o), .ext_wr_o(ext_wr), .ext_rd_o(ext_rd),
    .ext_dat_i(ext_dat_i), .ext_wack_i(ext_wack), .ext_rack_i(ext_rack)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] m_regs [4];
  logic [31:0] m_dat;

  typedef struct {
    int          resp_cyc;
    bit          is_err;
    int          n_resp;
    bit          both;
    logic [3:0]  wr1, rd1, regwr1;
    int          n_pulse, n_regwr;
    bit          stall1, stall_end;
    logic [31:0] dat_o, ext_dat;
    logic [127:0] reg_o;
  } obs_t;

  typedef struct {
    bit          w;
    logic [1:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    int          ack_at;
    logic [31:0] xd;
    int          e_cyc;
    bit          e_err;
    logic [31:0] e_dat;
    logic [31:0] e_slice;
  } vec_t;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] exp_reg_o();
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (!EXT[i]) r[i*32 +: 32] = m_regs[i];
    return r;
  endfunction

  // Abstract model: expected response cycle/type and the resulting register/read state
  task automatic model(input bit w, input logic [1:0] a, input logic [31:0] d, input logic [3:0] s,
                       input int ack_at, input logic [31:0] xd, output int e_cyc, output bit e_err);
    if (!EXT[a]) begin
      e_cyc = 1;
      e_err = 1'b0;
      if (w) begin
        for (int k = 0; k < 4; k++) if (s[k]) m_regs[a][8*k +: 8] = d[8*k +: 8];
      end else begin
        m_dat = m_regs[a];
      end
    end else if (ack_at >= 1 && ack_at <= TO) begin
      e_cyc = ack_at + 1;
      e_err = 1'b0;
      if (!w) m_dat = xd;
    end else begin
      e_cyc = TO + 1;
      e_err = 1'b1;
      if (!w) m_dat = '0;
    end
  endtask

  // One Wishbone transaction; ext ack for the target raised only in cycle ack_at, noise elsewhere
  task automatic txn(input bit w, input logic [1:0] a, input logic [31:0] d, input logic [3:0] s,
                     input int ack_at, input logic [31:0] xd, output obs_t o);
    o = '{default: 0};
    o.resp_cyc = -1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
    step();
    stb = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      ext_wack  = 4'($urandom);
      ext_rack  = 4'($urandom);
      ext_dat_i = {$urandom, $urandom, $urandom, $urandom};
      ext_dat_i[a*32 +: 32] = xd;
      if (w) ext_wack[a] = (c == ack_at);
      else   ext_rack[a] = (c == ack_at);
      if (c == 1) begin
        o.wr1 = ext_wr; o.rd1 = ext_rd; o.regwr1 = reg_wr; o.stall1 = stall;
      end
      o.n_pulse += $countones(ext_wr | ext_rd);
      o.n_regwr += $countones(reg_wr);
      if (ack && err) o.both = 1'b1;
      if (ack || err) begin
        o.n_resp++;
        if (o.resp_cyc < 0) begin
          o.resp_cyc = c;
          o.is_err   = err;
        end
      end
      step();
    end
    cyc = 1'b0; ext_wack = '0; ext_rack = '0;
    o.stall_end = stall; o.dat_o = dat_o; o.ext_dat = ext_dat_o; o.reg_o = reg_o;
  endtask

  task automatic check_obs(input string t, input obs_t o, input bit w, input logic [1:0] a,
                           input logic [31:0] d, input int e_cyc, input bit e_err,
                           input logic [31:0] e_dat, input logic [31:0] e_slice);
    logic [3:0] oh;
    bit x;
    oh = 4'b0001 << a;
    x  = EXT[a];
    chk({t, " resp_cycle"}, o.resp_cyc, e_cyc);
    chk({t, " err_flag"}, o.is_err, e_err);
    chk({t, " resp_count"}, o.n_resp, 1);
    chk({t, " ack_and_err"}, o.both, 0);
    chk({t, " wb_dat_o"}, o.dat_o, e_dat);
    chk({t, " reg_slice"}, o.reg_o[a*32 +: 32], e_slice);
    chk({t, " stall_cycle1"}, o.stall1, 1);
    chk({t, " stall_idle"}, o.stall_end, 0);
    chk({t, " ext_wr_cycle1"}, o.wr1, (x && w) ? oh : 4'b0);
    chk({t, " ext_rd_cycle1"}, o.rd1, (x && !w) ? oh : 4'b0);
    chk({t, " ext_pulse_count"}, o.n_pulse, x ? 1 : 0);
    chk({t, " reg_wr_cycle1"}, o.regwr1, (!x && w) ? oh : 4'b0);
    chk({t, " reg_wr_count"}, o.n_regwr, (!x && w) ? 1 : 0);
    if (x) chk({t, " ext_dat_o"}, o.ext_dat, d);
  endtask

  task automatic model_txn(input string t, input bit w, input logic [1:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int ack_at, input logic [31:0] xd);
    int   e_cyc;
    bit   e_err;
    obs_t o;
    model(w, a, d, s, ack_at, xd, e_cyc, e_err);
    txn(w, a, d, s, ack_at, xd, o);
    check_obs(t, o, w, a, d, e_cyc, e_err, m_dat, EXT[a] ? 32'h0 : m_regs[a]);
    chk({t, " reg_o"}, o.reg_o, exp_reg_o());
  endtask

  initial begin
    vec_t tbl [10];
    obs_t o;
    int   ec;
    bit   ee;
    int   nresp;

    tbl[0] = '{1'b0, 2'd0, 32'h0,        4'hF, 0, 32'h0,        1, 1'b0, 32'h0,        32'h0};
    tbl[1] = '{1'b1, 2'd1, 32'hAABBCCDD, 4'h5, 0, 32'h0,        1, 1'b0, 32'h0,        32'h00BB00DD};
    tbl[2] = '{1'b0, 2'd1, 32'h0,        4'hF, 0, 32'h0,        1, 1'b0, 32'h00BB00DD, 32'h00BB00DD};
    tbl[3] = '{1'b0, 2'd2, 32'h0,        4'hF, 4, 32'h12345678, 5, 1'b0, 32'h12345678, 32'h0};
    tbl[4] = '{1'b1, 2'd3, 32'h0BADCAFE, 4'hF, 0, 32'h0,        9, 1'b1, 32'h12345678, 32'h0};
    tbl[5] = '{1'b0, 2'd0, 32'h0,        4'hF, 0, 32'h0,        1, 1'b0, 32'h0,        32'h0};
    tbl[6] = '{1'b1, 2'd2, 32'h76543210, 4'h3, 8, 32'h0,        9, 1'b0, 32'h0,        32'h0};
    tbl[7] = '{1'b0, 2'd3, 32'h0,        4'hF, 1, 32'hCAFEF00D, 2, 1'b0, 32'hCAFEF00D, 32'h0};
    tbl[8] = '{1'b0, 2'd2, 32'h0,        4'hF, 0, 32'h5A5A5A5A, 9, 1'b1, 32'h0,        32'h0};
    tbl[9] = '{1'b1, 2'd0, 32'h11223344, 4'hF, 0, 32'h0,        1, 1'b0, 32'h0,        32'h11223344};

    rst_n = 1'b0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0; dat = '0;
    ext_dat_i = '0; ext_wack = '0; ext_rack = '0;
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_dat = '0;
    step();
    step();
    chk("reset outputs", {ack, err, stall, rty, dat_o, reg_wr, ext_dat_o, ext_wr, ext_rd}, '0);
    chk("reset reg_o", reg_o, '0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      model(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].ack_at, tbl[i].xd, ec, ee);
      txn(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].ack_at, tbl[i].xd, o);
      check_obs($sformatf("vec%0d", i), o, tbl[i].w, tbl[i].a, tbl[i].d,
                tbl[i].e_cyc, tbl[i].e_err, tbl[i].e_dat, tbl[i].e_slice);
    end

    // Master drops cyc after two WAIT cycles; a late write ack must produce nothing
    nresp = 0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 2'd3; dat = 32'h5555AAAA; sel = 4'hF;
    step();
    for (int c = 1; c <= 14; c++) begin
      stb = 1'b0;
      if (c >= 3) cyc = 1'b0;
      ext_wack = (c == 4) ? 4'b1000 : 4'b0000;
      if (c == 3) chk("abort stall_in_wait", stall, 1);
      if (ack || err) nresp++;
      step();
    end
    ext_wack = '0;
    chk("abort response_count", nresp, 0);
    chk("abort stall_idle", stall, 0);
    model_txn("post_abort", 1'b0, 2'd0, 32'h0, 4'hF, 0, 32'h0);

    for (int i = 0; i < 40; i++) begin
      model_txn($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 2'($urandom), $urandom,
                4'($urandom), int'($urandom_range(0, 11)), $urandom);
    end

    // Reset pulsed while waiting on an external read
    model_txn("pre_reset", 1'b1, 2'd1, 32'hDEADBEEF, 4'hF, 0, 32'h0);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 2'd3; dat = 32'h01020304; sel = 4'hF;
    step();
    stb = 1'b0;
    step();
    chk("reset_wait stall", stall, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset outputs", {ack, err, stall, rty, dat_o, reg_wr, ext_dat_o, ext_wr, ext_rd}, '0);
    chk("async reset reg_o", reg_o, '0);
    cyc = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_dat = '0;
    step();
    model_txn("post_reset", 1'b0, 2'd0, 32'h0, 4'hF, 0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
